// File: rtl/wfg_stim_capture_top.sv
// -----------------------------------------------------------------------------
// wfg_stim_capture_top
//
// Capture sink for the 18-bit signed stimulus AXI-Stream of the wfg_stim_*
// generators. Accepted samples are optionally decimated and stored in a FIFO
// that software drains over the common wfg_* Wishbone slave port. In
// continuous mode a store into a full FIFO sets the sticky OVF flag. In
// one-shot mode capture stops (tready low) once the FIFO is full.
//
// Ports
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   wbs_stb_i/cyc_i/we_i          Wishbone request qualifiers
//   wbs_sel_i                     byte selects (ignored, writes are full-word)
//   wbs_adr_i                     byte address, word index taken from [4:2]
//   wbs_dat_i / wbs_dat_o         write / registered read data
//   wbs_ack_o                     one-cycle registered acknowledge
//   wfg_stim_capture_tvalid_i     stream valid from the generator
//   wfg_stim_capture_tready_o     stream ready to the generator
//   wfg_stim_capture_tdata_i      signed 18-bit sample
//
// Register map (word index)
//   0 CTRL   RW  bit0 EN, bit1 ONESHOT, bit2 CLR (write-1 pulse, reads 0)
//   1 STATUS RO  [8:0] LEVEL, 16 EMPTY, 17 FULL, 18 OVF, 19 DONE
//   2 DATA   RO  pops the FIFO, sign-extended sample; 0 and no pop when empty
//   3 DECIM  RW  [15:0] N, one of every N+1 accepted samples is stored
//   4 ID     RO  0x0001_0003
//   5..7         read 0, writes ignored
//
// Handshakes
//   Wishbone: a request is stb & cyc & !ack; ack follows one cycle later and
//   writes/read data take effect at the edge that raises ack.
//   Stream: a sample transfers on tvalid & tready; tready = EN & !DONE and is
//   a function of registered state only.
// -----------------------------------------------------------------------------
module wfg_stim_capture_top #(
   parameter int BUSW  = 32,
   parameter int DEPTH = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_we_i,
   input  logic [BUSW/8-1:0] wbs_sel_i,
   input  logic [BUSW-1:0]   wbs_dat_i,
   input  logic [BUSW-1:0]   wbs_adr_i,
   output logic              wbs_ack_o,
   output logic [BUSW-1:0]   wbs_dat_o,
   input  logic              wfg_stim_capture_tvalid_i,
   output logic              wfg_stim_capture_tready_o,
   input  logic [17:0]       wfg_stim_capture_tdata_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [31:0] ID_VALUE = 32'h0001_0003;

   localparam logic [2:0] A_CTRL   = 3'd0;
   localparam logic [2:0] A_STATUS = 3'd1;
   localparam logic [2:0] A_DATA   = 3'd2;
   localparam logic [2:0] A_DECIM  = 3'd3;
   localparam logic [2:0] A_ID     = 3'd4;

   // Registered state
   logic            r_ack;
   logic [31:0]     r_dat;
   logic            r_en;
   logic            r_oneshot;
   logic [15:0]     r_decim;
   logic [15:0]     r_dec_cnt;
   logic            r_ovf;
   logic            r_done;
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [LW-1:0]   r_level;
   logic [17:0]     r_mem [DEPTH];

   // Combinational decode
   logic            w_req;
   logic            w_wr_req;
   logic            w_rd_req;
   logic [2:0]      w_idx;
   logic            w_clr;
   logic            w_empty;
   logic            w_full;
   logic            w_pop;
   logic            w_tready;
   logic            w_xfer;
   logic            w_keep;
   logic            w_push;
   logic            w_ovf_set;
   logic            w_fill;
   logic [31:0]     w_status;
   logic [31:0]     w_rd_data;
   logic            w_unused;

   assign w_unused = ^{wbs_sel_i, wbs_adr_i[BUSW-1:5], wbs_adr_i[1:0],
                       wbs_dat_i[BUSW-1:16]};

   assign w_req    = wbs_stb_i & wbs_cyc_i & ~r_ack;
   assign w_wr_req = w_req & wbs_we_i;
   assign w_rd_req = w_req & ~wbs_we_i;
   assign w_idx    = wbs_adr_i[4:2];

   assign w_clr    = w_wr_req & (w_idx == A_CTRL) & wbs_dat_i[2];
   assign w_empty  = (r_level == '0);
   assign w_full   = (r_level == LW'(DEPTH));
   assign w_pop    = w_rd_req & (w_idx == A_DATA) & ~w_empty;

   assign w_tready = r_en & ~r_done;
   assign w_xfer   = wfg_stim_capture_tvalid_i & w_tready;

   // A transfer coinciding with CLR is consumed but never stored.
   assign w_keep    = w_xfer & (r_dec_cnt == 16'd0) & ~w_clr;
   // A pop in the same cycle frees the slot, so a store into a full FIFO
   // still succeeds in that case.
   assign w_push    = w_keep & (~w_full | w_pop);
   assign w_ovf_set = w_keep & w_full & ~w_pop;
   // The edge on which LEVEL reaches DEPTH.
   assign w_fill    = w_push & ~w_pop & (r_level == LW'(DEPTH - 1));

   always_comb begin
      w_status             = '0;
      w_status[LW-1:0]     = r_level;
      w_status[16]         = w_empty;
      w_status[17]         = w_full;
      w_status[18]         = r_ovf;
      w_status[19]         = r_done;
   end

   always_comb begin
      w_rd_data = '0;
      case (w_idx)
         A_CTRL:   w_rd_data = {30'd0, r_oneshot, r_en};
         A_STATUS: w_rd_data = w_status;
         A_DATA:   if (!w_empty) begin
                      w_rd_data = {{14{r_mem[r_rd_ptr][17]}}, r_mem[r_rd_ptr]};
                   end
         A_DECIM:  w_rd_data = {16'd0, r_decim};
         A_ID:     w_rd_data = ID_VALUE;
         default:  w_rd_data = '0;
      endcase
   end

   // Wishbone slave: ack, read data and writable registers
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ack     <= 1'b0;
         r_dat     <= '0;
         r_en      <= 1'b0;
         r_oneshot <= 1'b0;
         r_decim   <= '0;
      end else begin
         r_ack <= w_req;
         if (w_rd_req) begin
            r_dat <= w_rd_data;
         end
         if (w_wr_req) begin
            case (w_idx)
               A_CTRL: begin
                  r_en      <= wbs_dat_i[0];
                  r_oneshot <= wbs_dat_i[1];
               end
               A_DECIM: r_decim <= wbs_dat_i[15:0];
               default: ;
            endcase
         end
      end
   end

   // Decimation counter: held at 0 while disabled so that the first
   // transfer after enable is always stored.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || w_clr || !r_en) begin
         r_dec_cnt <= '0;
      end else if (w_xfer) begin
         r_dec_cnt <= (r_dec_cnt == 16'd0) ? r_decim : (r_dec_cnt - 16'd1);
      end
   end

   // FIFO pointers, level and status flags
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || w_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_ovf    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_level <= r_level + LW'(w_push) - LW'(w_pop);
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end
         if (r_oneshot && w_fill) begin
            r_done <= 1'b1;
         end
      end
   end

   // Sample storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge wb_clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wfg_stim_capture_tdata_i;
      end
   end

   assign wbs_ack_o                 = r_ack;
   assign wbs_dat_o                 = r_dat;
   assign wfg_stim_capture_tready_o = w_tready;

endmodule
